// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared state encodings and stage payload widths for pipeline regs.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 40;
   localparam int IF_ID_W = PC_W + INSTR_W;

   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_ONE   = ST_ONE,
      S_TWO   = ST_TWO
   } state_t;

   function automatic logic [1:0] state_count(input state_t s);
      case (s)
         S_ONE:   state_count = 2'd1;
         S_TWO:   state_count = 2'd2;
         default: state_count = 2'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_data_reg
// Purpose  : DATA_W-bit payload register with load enable, async reset value.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_data_reg #(
   parameter int                DATA_W   = 72,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_q <= RST_DATA;
      else if (en)
         r_q <= d;
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_pr.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_pr
// Purpose  : Valid/ready pipeline register with optional 2-entry skid buffer
//            and synchronous flush for redirects.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_pr
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = IF_ID_W,
   parameter int                SKID     = 1,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_fire;
   logic              w_main_en;
   logic              w_main_from_skid;
   logic              w_skid_en;
   logic [DATA_W-1:0] w_main_d;
   logic [DATA_W-1:0] w_skid_q;

   assign out_valid = (r_state == S_ONE) || (r_state == S_TWO);
   assign count     = state_count(r_state);
   assign w_accept  = in_valid & in_ready;
   assign w_fire    = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_EMPTY;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_main_en        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_en        = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = S_ONE;
               w_main_en   = 1'b1;
            end
         end
         S_ONE: begin
            if (w_accept && w_fire) begin
               w_main_en = 1'b1;
            end else if (w_accept) begin
               // Only reachable with a skid entry; without one in_ready
               // already requires a concurrent fire.
               if (SKID != 0) begin
                  w_state_nxt = S_TWO;
                  w_skid_en   = 1'b1;
               end
            end else if (w_fire) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_fire) begin
               w_state_nxt      = S_ONE;
               w_main_en        = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      // Flush empties the stage; payload registers keep their contents.
      if (flush) begin
         w_state_nxt      = S_EMPTY;
         w_main_en        = 1'b0;
         w_main_from_skid = 1'b0;
         w_skid_en        = 1'b0;
      end
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

   pipe_data_reg #(
      .DATA_W   (DATA_W),
      .RST_DATA (RST_DATA)
   ) u_main (
      .clk (clk),
      .rst (rst),
      .en  (w_main_en),
      .d   (w_main_d),
      .q   (out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic r_in_ready;

         // Registered ready cuts the out_ready -> in_ready path.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_in_ready <= 1'b1;
            else
               r_in_ready <= (w_state_nxt != S_TWO);
         end

         assign in_ready = r_in_ready;

         pipe_data_reg #(
            .DATA_W   (DATA_W),
            .RST_DATA (RST_DATA)
         ) u_skid (
            .clk (clk),
            .rst (rst),
            .en  (w_skid_en),
            .d   (in_data),
            .q   (w_skid_q)
         );
      end else begin : g_comb
         assign in_ready = !out_valid || out_ready;
         assign w_skid_q = RST_DATA;
      end
   endgenerate

endmodule
`default_nettype wire
